// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: per-bit control codes, R-type funct codes, FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_serial_seq_if.sv
// Start/done request bundle between the control FSM (master) and the serial ALU (slave).
interface alu_serial_seq_if #(parameter int WIDTH = 32);

  logic             start;
  logic [5:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, funct, a, b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, funct, a, b,
    output busy, done, result, zero, illegal
  );

endinterface

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decode to per-bit ALU control; zero latency, no flow control.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] ctl,
  output logic       inv,
  output logic       illegal
);

  always_comb begin
    ctl     = ALU_AND;
    inv     = 1'b0;
    illegal = 1'b0;
    case (funct)
      FUNCT_ADD: ctl = ALU_ADD;
      FUNCT_SUB: begin ctl = ALU_SUB; inv = 1'b1; end
      FUNCT_AND: ctl = ALU_AND;
      FUNCT_OR:  ctl = ALU_OR;
      FUNCT_SLT: begin ctl = ALU_SLT; inv = 1'b1; end
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: one result bit per cycle LSB-first, done WIDTH cycles after start is
// sampled; start is only honoured while idle, so the requester must hold or retry it.
module alu_serial_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  alu_serial_seq_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, shift_q, result_q;
  logic [WIDTH-1:0] shift_nxt, fin_result;
  logic [2:0]       ctl_q;
  logic             inv_q, bad_q, carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_q, illegal_q;

  logic [2:0] dec_ctl;
  logic       dec_inv, dec_illegal;
  logic       ai, bi, bx, s, cout, bit_out, slt_bit;

  alu_funct_decode u_dec (
    .funct   (bus.funct),
    .ctl     (dec_ctl),
    .inv     (dec_inv),
    .illegal (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt_q == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One full-adder slice; the last bit's result is folded straight into the final value so
  // that result is already valid in the cycle done is high.
  always_comb begin
    ai        = a_q[cnt_q];
    bi        = b_q[cnt_q];
    bx        = bi ^ inv_q;
    s         = ai ^ bx ^ carry_q;
    cout      = (ai & bx) | (ai & carry_q) | (bx & carry_q);
    case (ctl_q)
      ALU_AND: bit_out = ai & bi;
      ALU_OR:  bit_out = ai | bi;
      default: bit_out = s;
    endcase
    shift_nxt = {bit_out, shift_q[WIDTH-1:1]};
    // Sign of the true difference: MSB sum corrected by the overflow flag.
    slt_bit   = s ^ (carry_q ^ cout);
    if (bad_q)                fin_result = '0;
    else if (ctl_q == ALU_SLT) fin_result = {{(WIDTH-1){1'b0}}, slt_bit};
    else                      fin_result = shift_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      shift_q   <= '0;
      result_q  <= '0;
      ctl_q     <= ALU_AND;
      inv_q     <= 1'b0;
      bad_q     <= 1'b0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            ctl_q   <= dec_ctl;
            inv_q   <= dec_inv;
            bad_q   <= dec_illegal;
            carry_q <= dec_inv;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        RUN: begin
          carry_q <= cout;
          shift_q <= shift_nxt;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            result_q  <= fin_result;
            zero_q    <= (fin_result == '0);
            illegal_q <= bad_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = (state != IDLE);
  assign bus.done    = (state == FIN);
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Randomized bench for alu_serial_seq with a cycle-level reference model and literal spot checks.
module tb_alu_serial_seq;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state: the accepted op and the output values the bench expects to be held.
  bit           have_op = 1'b0;
  int           e0 = 0;
  logic [W-1:0] pend_res = '0;
  logic         pend_zero = 1'b1, pend_ill = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic         exp_zero = 1'b1, exp_ill = 1'b0;
  logic         exp_busy, exp_done;

  function automatic logic [W+1:0] ref_op(input logic [5:0] f, input logic [W-1:0] x,
                                          input logic [W-1:0] y);
    logic [W-1:0] r;
    logic         ill;
    ill = 1'b0;
    case (f)
      FUNCT_ADD: r = x + y;
      FUNCT_SUB: r = x - y;
      FUNCT_AND: r = x & y;
      FUNCT_OR:  r = x | y;
      FUNCT_SLT: r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      default: begin r = '0; ill = 1'b1; end
    endcase
    return {ill, (r == '0), r};
  endfunction

  // An op is accepted on the edge that sees start while idle; done appears W cycles later,
  // and the unit is idle again one cycle after done.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      have_op  = 1'b0;
      exp_res  = '0;
      exp_zero = 1'b1;
      exp_ill  = 1'b0;
    end else begin
      if (have_op && cyc == e0 + W) begin
        exp_res  = pend_res;
        exp_zero = pend_zero;
        exp_ill  = pend_ill;
      end
      if (bus.start === 1'b1 && (!have_op || cyc >= e0 + W + 2)) begin
        have_op = 1'b1;
        e0      = cyc;
        {pend_ill, pend_zero, pend_res} = ref_op(bus.funct, bus.a, bus.b);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      exp_busy = have_op && cyc >= e0 && cyc <= e0 + W;
      exp_done = have_op && cyc == e0 + W;
      n_cmp++;
      if (bus.busy !== exp_busy || bus.done !== exp_done || bus.result !== exp_res ||
          bus.zero !== exp_zero || bus.illegal !== exp_ill) begin
        n_bad++;
        $display("FAIL cycle %0d outputs: got busy=%0b done=%0b result=%h zero=%0b illegal=%0b, want busy=%0b done=%0b result=%h zero=%0b illegal=%0b",
                 cyc, bus.busy, bus.done, bus.result, bus.zero, bus.illegal,
                 exp_busy, exp_done, exp_res, exp_zero, exp_ill);
      end
    end
  end

  // Issue one op and check the literal answer and the done latency (edges after start is raised).
  task automatic run_lit(input string name, input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [W-1:0] want, input logic wz,
                         input logic wi, input bit junk);
    int n;
    bit seen;
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.funct = f; bus.a = x; bus.b = y;
    n = 0;
    seen = 1'b0;
    while (!seen && n < W + 8) begin
      @(posedge clk);
      n++;
      #2;
      bus.start = junk && (n == 5);
      if (bus.start) begin
        bus.funct = FUNCT_OR; bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != W + 1 || bus.result !== want || bus.zero !== wz || bus.illegal !== wi) begin
      n_bad++;
      $display("FAIL %s: got seen=%0b edges=%0d result=%h zero=%0b illegal=%0b, want edges=%0d result=%h zero=%0b illegal=%0b",
               name, seen, n, bus.result, bus.zero, bus.illegal, W + 1, want, wz, wi);
    end
  endtask

  task automatic run_rand();
    logic [5:0] f;
    logic [W-1:0] x, y;
    int k, n;
    bit seen;
    case ($urandom_range(0, 7))
      0: f = FUNCT_ADD;
      1: f = FUNCT_SUB;
      2: f = FUNCT_AND;
      3: f = FUNCT_OR;
      4, 5: f = FUNCT_SLT;
      6: f = FUNCT_SUB;
      default: f = 6'($urandom);
    endcase
    x = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : W'($urandom);
    y = ($urandom_range(0, 5) == 0) ? 32'h7FFF_FFFF : W'($urandom);
    if ($urandom_range(0, 9) == 0) y = x;
    k = $urandom_range(2, W - 2);
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.funct = f; bus.a = x; bus.b = y;
    n = 0;
    seen = 1'b0;
    while (!seen && n < W + 8) begin
      @(posedge clk);
      n++;
      #2;
      bus.start = ($urandom_range(0, 3) == 0) && (n == k);
      if (bus.start) begin
        bus.funct = 6'($urandom); bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL random op timeout: got no done in %0d cycles, want done", n);
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b1 ||
        bus.illegal !== 1'b0) begin
      n_bad++;
      $display("FAIL reset state: got busy=%0b done=%0b result=%h zero=%0b illegal=%0b, want 0 0 0 1 0",
               bus.busy, bus.done, bus.result, bus.zero, bus.illegal);
    end

    run_lit("add 5+7", FUNCT_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, 1'b0);
    run_lit("sub 3-5", FUNCT_SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_lit("sub 9-9", FUNCT_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, 1'b0);
    run_lit("slt -1<1", FUNCT_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    run_lit("slt ovf", FUNCT_SLT, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 1'b0);
    run_lit("slt min<1", FUNCT_SLT, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
    run_lit("and", FUNCT_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0);
    run_lit("or", FUNCT_OR, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0);
    run_lit("illegal 3f", 6'h3F, 32'h1234_5678, 32'h1, 32'd0, 1'b1, 1'b1, 1'b0);
    run_lit("start ignored in run", FUNCT_ADD, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 1'b1);

    // Abort an add partway through with reset.
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.funct = FUNCT_ADD; bus.a = 32'h1234; bus.b = 32'h4321;
    @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.zero !== 1'b1) begin
      n_bad++;
      $display("FAIL mid-op reset: got busy=%0b done=%0b result=%h zero=%0b, want 0 0 0 1",
               bus.busy, bus.done, bus.result, bus.zero);
    end
    run_lit("add after abort", FUNCT_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 1'b0, 1'b0);

    // Start held high: the model accepts a new op every time the unit returns to idle.
    @(posedge clk);
    #2;
    bus.start = 1'b1; bus.funct = FUNCT_SUB; bus.a = 32'd50; bus.b = 32'd8;
    repeat (2 * (W + 2) + 3) @(posedge clk);
    #2 bus.start = 1'b0;
    repeat (W + 4) @(posedge clk);

    for (int i = 0; i < 150; i++) run_rand();
    repeat (W + 4) @(posedge clk);

    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
